arbiter_request_queue: RTL and testbench

ARBITER_REQUEST_QUEUE -- requirements
Module: arbiter_request_queue

---
 rtl/arbiter_request_queue.sv | 124 ++++++++++++
 tb/tb_arbiter_request_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_request_queue.sv
// Two per-client job FIFOs that feed a round-robin arbiter and present each granted job one cycle later.
// Optional grant-protocol checker enabled by defining ARB_REQ_QUEUE_PROTOCOL_CHECK_EN.
module arbiter_request_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic [1:0]       requests,
    input  logic [1:0]       grants,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] in_data [2];
    logic [WIDTH-1:0] mem_q   [2][DEPTH];
    logic [AW-1:0]    wr_ptr_q [2], wr_ptr_d [2];
    logic [AW-1:0]    rd_ptr_q [2], rd_ptr_d [2];
    logic [CW-1:0]    cnt_q    [2], cnt_d    [2];
    logic [1:0]       ready;
    logic [1:0]       push;
    logic [1:0]       pop;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_src_q;

    assign in_data[0] = in0_data;
    assign in_data[1] = in1_data;

    // Ready and requests come only from registered occupancy, never from this cycle's grants.
    assign ready[0]    = (cnt_q[0] < CW'(DEPTH));
    assign ready[1]    = (cnt_q[1] < CW'(DEPTH));
    assign requests[0] = (cnt_q[0] != '0);
    assign requests[1] = (cnt_q[1] != '0);
    assign in0_ready   = ready[0];
    assign in1_ready   = ready[1];

    assign push   = {in1_valid, in0_valid} & ready;
    assign pop[0] = (grants == 2'b01) && requests[0];
    assign pop[1] = (grants == 2'b10) && requests[1];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            wr_ptr_d[k] = wr_ptr_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            if (push[k]) wr_ptr_d[k] = wr_ptr_q[k] + AW'(1);
            if (pop[k])  rd_ptr_d[k] = rd_ptr_q[k] + AW'(1);
            cnt_d[k] = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
        end
    end

    // NOTE: payload storage is deliberately not reset; emptiness is tracked by cnt_q, so stale words are never observed.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k]) mem_q[k][wr_ptr_q[k]] <= in_data[k];
        end
    end

    // At most one pop per edge, so pop[1] alone selects the source FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else begin
            out_valid_q <= |pop;
            if (|pop) begin
                out_src_q  <= pop[1];
                out_data_q <= mem_q[pop[1]][rd_ptr_q[pop[1]]];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef ARB_REQ_QUEUE_PROTOCOL_CHECK_EN
    logic proto_err_q;
    logic illegal_grant;

    assign illegal_grant = (grants == 2'b11)
                         || (grants[0] && !requests[0])
                         || (grants[1] && !requests[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             proto_err_q <= 1'b0;
        else if (illegal_grant) proto_err_q <= 1'b1;
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_arbiter_request_queue.sv
// Directed bench for arbiter_request_queue: a DEPTH=2 instance for most scenarios and a DEPTH=4 instance for pointer wrap.
module tb_arbiter_request_queue;

`ifdef ARB_REQ_QUEUE_PROTOCOL_CHECK_EN
    localparam logic EXP_PE = 1'b1;
`else
    localparam logic EXP_PE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in0_valid, in1_valid;
    logic [7:0] in0_data, in1_data;
    logic       in0_ready, in1_ready;
    logic [1:0] requests, grants;
    logic       out_valid, out_src, proto_err;
    logic [7:0] out_data;

    logic       d4_in0_valid, d4_in1_valid;
    logic [7:0] d4_in0_data, d4_in1_data;
    logic       d4_in0_ready, d4_in1_ready;
    logic [1:0] d4_requests, d4_grants;
    logic       d4_out_valid, d4_out_src, d4_proto_err;
    logic [7:0] d4_out_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    arbiter_request_queue #(.WIDTH(8), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .requests(requests), .grants(grants),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .proto_err(proto_err)
    );

    arbiter_request_queue #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(d4_in0_valid), .in0_data(d4_in0_data), .in0_ready(d4_in0_ready),
        .in1_valid(d4_in1_valid), .in1_data(d4_in1_data), .in1_ready(d4_in1_ready),
        .requests(d4_requests), .grants(d4_grants),
        .out_valid(d4_out_valid), .out_data(d4_out_data), .out_src(d4_out_src),
        .proto_err(d4_proto_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic s);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_src"},   32'(out_src),   32'(s));
    endtask

    initial begin
        rst_n = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0; in0_data = '0; in1_data = '0; grants = 2'b00;
        d4_in0_valid = 1'b0; d4_in1_valid = 1'b0; d4_in0_data = '0; d4_in1_data = '0; d4_grants = 2'b00;

        // Reset state
        #2;
        check("rst_requests", 32'(requests), 32'h0);
        check("rst_ready0", 32'(in0_ready), 32'h1);
        check("rst_ready1", 32'(in1_ready), 32'h1);
        check_out("rst_out", 1'b0, 8'h00, 1'b0);
        check("rst_proto_err", 32'(proto_err), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Single job
        in0_valid = 1'b1; in0_data = 8'hA5;
        tick();
        in0_valid = 1'b0;
        check("single_requests", 32'(requests), 32'h1);
        grants = 2'b01;
        tick();
        grants = 2'b00;
        check_out("single_out", 1'b1, 8'hA5, 1'b0);
        check("single_req_after", 32'(requests), 32'h0);
        tick();
        check_out("single_hold", 1'b0, 8'hA5, 1'b0);

        // Alternating service, simultaneous pushes to both FIFOs
        in0_valid = 1'b1; in0_data = 8'h11; in1_valid = 1'b1; in1_data = 8'h21;
        tick();
        in0_data = 8'h12; in1_data = 8'h22;
        tick();
        in0_valid = 1'b0; in1_valid = 1'b0;
        check("alt_requests", 32'(requests), 32'h3);
        check("alt_ready", 32'({in1_ready, in0_ready}), 32'h0);
        grants = 2'b01; tick(); check_out("alt_o1", 1'b1, 8'h11, 1'b0);
        grants = 2'b10; tick(); check_out("alt_o2", 1'b1, 8'h21, 1'b1);
        grants = 2'b01; tick(); check_out("alt_o3", 1'b1, 8'h12, 1'b0);
        grants = 2'b10; tick(); check_out("alt_o4", 1'b1, 8'h22, 1'b1);
        grants = 2'b00;
        check("alt_req_empty", 32'(requests), 32'h0);
        tick();
        check("alt_idle_valid", 32'(out_valid), 32'h0);

        // Full FIFO rejects the third job
        in1_valid = 1'b1; in1_data = 8'h31; tick();
        check("full_ready_1", 32'(in1_ready), 32'h1);
        in1_data = 8'h32; tick();
        check("full_ready_2", 32'(in1_ready), 32'h0);
        in1_data = 8'h33; tick();
        in1_valid = 1'b0;
        check("full_ready_3", 32'(in1_ready), 32'h0);
        check("full_requests", 32'(requests), 32'h2);
        grants = 2'b10; tick(); grants = 2'b00;
        check_out("full_o1", 1'b1, 8'h31, 1'b1);
        check("full_ready_back", 32'(in1_ready), 32'h1);
        grants = 2'b10; tick(); grants = 2'b00;
        check_out("full_o2", 1'b1, 8'h32, 1'b1);
        check("full_no_third", 32'(requests), 32'h0);
        check("full_pe_clean", 32'(proto_err), 32'h0);

        // Illegal grant 2'b11 with both FIFOs holding data
        in0_valid = 1'b1; in0_data = 8'h41; in1_valid = 1'b1; in1_data = 8'h51;
        tick();
        in0_valid = 1'b0; in1_valid = 1'b0;
        grants = 2'b11; tick(); grants = 2'b00;
        check("ill_valid", 32'(out_valid), 32'h0);
        check("ill_requests", 32'(requests), 32'h3);
        check("ill_ready", 32'({in1_ready, in0_ready}), 32'h3);
        check("ill_pe", 32'(proto_err), 32'(EXP_PE));
        tick();
        check("ill_pe_sticky", 32'(proto_err), 32'(EXP_PE));
        grants = 2'b01; tick(); check_out("ill_o1", 1'b1, 8'h41, 1'b0);
        grants = 2'b10; tick(); check_out("ill_o2", 1'b1, 8'h51, 1'b1);
        grants = 2'b01; tick(); grants = 2'b00;
        check("empty_grant_valid", 32'(out_valid), 32'h0);
        check("empty_grant_req", 32'(requests), 32'h0);
        check("pe_still", 32'(proto_err), 32'(EXP_PE));

        // Reset mid-burst with a pending output pulse
        in0_valid = 1'b1; in0_data = 8'h61; in1_valid = 1'b1; in1_data = 8'h71; tick();
        in0_data = 8'h62; in1_data = 8'h72; tick();
        in0_valid = 1'b0; in1_valid = 1'b0;
        grants = 2'b01; tick(); grants = 2'b00;
        check_out("pre_rst_out", 1'b1, 8'h61, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_requests", 32'(requests), 32'h0);
        check("mid_rst_ready", 32'({in1_ready, in0_ready}), 32'h3);
        check_out("mid_rst_out", 1'b0, 8'h00, 1'b0);
        check("mid_rst_pe", 32'(proto_err), 32'h0);
        #1 rst_n = 1'b1;
        grants = 2'b01; tick();
        grants = 2'b10; tick(); grants = 2'b00;
        check("post_rst_valid", 32'(out_valid), 32'h0);
        check("post_rst_req", 32'(requests), 32'h0);
        in0_valid = 1'b1; in0_data = 8'h81; tick(); in0_valid = 1'b0;
        check("post_rst_push", 32'(requests), 32'h1);
        grants = 2'b01; tick(); grants = 2'b00;
        check_out("post_rst_o", 1'b1, 8'h81, 1'b0);

        // Pointer wrap on the DEPTH=4 instance
        d4_in0_valid = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            d4_in0_data = 8'(v);
            tick();
        end
        for (int v = 4; v <= 10; v++) begin
            d4_in0_data = 8'(v);
            d4_grants = 2'b01;
            tick();
            check("wrap_valid", 32'(d4_out_valid), 32'h1);
            check("wrap_data", 32'(d4_out_data), 32'(v - 3));
            check("wrap_ready", 32'(d4_in0_ready), 32'h1);
        end
        d4_in0_valid = 1'b0;
        for (int v = 8; v <= 10; v++) begin
            tick();
            check("drain_valid", 32'(d4_out_valid), 32'h1);
            check("drain_data", 32'(d4_out_data), 32'(v));
        end
        d4_grants = 2'b00;
        check("wrap_req_empty", 32'(d4_requests), 32'h0);
        tick();
        check("wrap_idle", 32'(d4_out_valid), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
